// File: rtl/mem_arb_if.sv
// mem_arb_if: requester, downstream memory and status bundle for mem_arb.
// slave = arbiter view, master = requesters/memory view.
interface mem_arb_if #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
) ();
  localparam int MW = DW / 8;

  logic [NCH-1:0]    req_valid;
  logic [NCH-1:0]    req_ready;
  logic [NCH-1:0]    req_wen;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*DW-1:0] req_wdata;
  logic [NCH*MW-1:0] req_wmask;
  logic [NCH-1:0]    rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              m_req_valid;
  logic              m_req_ready;
  logic              m_wen;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_wdata;
  logic [MW-1:0]     m_wmask;
  logic              m_rsp_valid;
  logic [DW-1:0]     m_rsp_rdata;
  logic              busy;

  modport slave (
    input  req_valid, req_wen, req_addr,
    input  req_wdata, req_wmask,
    input  m_req_ready, m_rsp_valid, m_rsp_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output m_req_valid, m_wen, m_addr,
    output m_wdata, m_wmask, busy
  );

  modport master (
    output req_valid, req_wen, req_addr,
    output req_wdata, req_wmask,
    output m_req_ready, m_rsp_valid, m_rsp_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  m_req_valid, m_wen, m_addr,
    input  m_wdata, m_wmask, busy
  );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: N-channel round-robin arbiter onto one memory port.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module mem_arb #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input logic     clk,
  input logic     rst,
  mem_arb_if.slave bus
);
  localparam int MW = DW / 8;
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, RESP
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] own_q, ptr_q, win;
  logic          found, grant;
  int            idx;
  logic          wen_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q;
  logic [MW-1:0] wmask_q;

  // Scan channels from the pointer upward with wrap; first valid wins
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && bus.req_valid[idx]) begin
        win   = PW'(idx);
        found = 1'b1;
      end
    end
  end

  // No acceptance while reset is applied, so no handshake is lost
  assign grant = rst && (state_q == IDLE) && found;

  // Next state and handshake outputs
  always_comb begin
    state_d         = state_q;
    bus.req_ready   = '0;
    bus.rsp_valid   = '0;
    bus.m_req_valid = 1'b0;
    bus.busy        = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          bus.req_ready = NCH'(1) << win;
          state_d       = REQ;
        end
      end
      REQ: begin
        bus.m_req_valid = 1'b1;
        if (bus.m_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.m_rsp_valid) state_d = RESP;
      end
      RESP: begin
        bus.rsp_valid = NCH'(1) << own_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Latch owner and payload at accept, read data in WAIT
  always_ff @(posedge clk) begin
    if (!rst) begin
      own_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      if (grant) begin
        own_q   <= win;
        wen_q   <= bus.req_wen[win];
        addr_q  <= bus.req_addr[int'(win)*AW +: AW];
        wdata_q <= bus.req_wdata[int'(win)*DW +: DW];
        wmask_q <= bus.req_wmask[int'(win)*MW +: MW];
      end
      if (state_q == WAIT && bus.m_rsp_valid)
        rdata_q <= bus.m_rsp_rdata;
    end
  end

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  // Pointer moves just past the owner once its response is out
  always_ff @(posedge clk) begin
    if (!rst)
      ptr_q <= '0;
    else if (state_q == RESP)
      ptr_q <= (int'(own_q) == NCH - 1) ? '0 : own_q + 1'b1;
  end
`endif

  assign bus.m_wen     = wen_q;
  assign bus.m_addr    = addr_q;
  assign bus.m_wdata   = wdata_q;
  assign bus.m_wmask   = wmask_q;
  assign bus.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed bench for mem_arb with a transaction-level model.
// Honours MEM_ARB_FIXED_PRIO_EN for expected grant order.
module tb_mem_arb;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arb_if #(.NCH(N), .AW(AW), .DW(DW)) bus ();

  mem_arb #(.NCH(N), .AW(AW), .DW(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- model ----------------
  bit          mv, live, issued, back;
  int          own, rr, w;
  logic [N-1:0] er;
  logic        p_wen;
  logic [31:0] p_addr, p_wdata, rd_m;
  logic [3:0]  p_wmask;
  int          grants[$];
  int          rsp_n[N];
  int          rsp_tot, mreq_cyc, cyc, g_cyc, r_cyc;

  function automatic int pick(logic [N-1:0] v, int p);
    int s;
    s = p;
`ifdef MEM_ARB_FIXED_PRIO_EN
    s = 0;
`endif
    for (int k = 0; k < N; k++)
      if (v[(s + k) % N]) return (s + k) % N;
    return -1;
  endfunction

  function automatic int gat(int i);
    return (i < grants.size()) ? grants[i] : -1;
  endfunction

  // Compare DUT against the model, then advance the model one cycle
  always @(negedge clk) begin
    cyc++;
    w  = pick(bus.req_valid, rr);
    er = (rst && !live && w >= 0) ? (N'(1) << w) : '0;
    if (mv) begin
      chk("req_ready", bus.req_ready, er);
      chk("busy", bus.busy, live);
      chk("m_req_valid", bus.m_req_valid, live && !issued);
      chk("rsp_valid", bus.rsp_valid,
          back ? (N'(1) << own) : '0);
      if (back) chk("rsp_rdata", bus.rsp_rdata, rd_m);
      if (live && !issued) begin
        chk("m_wen", bus.m_wen, p_wen);
        chk("m_addr", bus.m_addr, p_addr);
        chk("m_wdata", bus.m_wdata, p_wdata);
        chk("m_wmask", bus.m_wmask, p_wmask);
      end
    end
    if (bus.rsp_valid != '0) begin
      rsp_tot++;
      r_cyc = cyc;
      for (int c = 0; c < N; c++)
        if (bus.rsp_valid[c]) rsp_n[c]++;
    end
    if (bus.m_req_valid) mreq_cyc++;
    if (!rst) begin
      mv = 1; live = 0; issued = 0; back = 0; rr = 0;
      rd_m = '0;
    end else if (mv) begin
      if (back) begin
        live = 0; issued = 0; back = 0;
        rr = (own + 1) % N;
      end else if (live && !issued) begin
        if (bus.m_req_ready) issued = 1;
      end else if (live && issued) begin
        if (bus.m_rsp_valid) begin
          back = 1;
          rd_m = bus.m_rsp_rdata;
        end
      end else if (er != '0) begin
        live    = 1;
        own     = w;
        g_cyc   = cyc;
        grants.push_back(w);
        p_wen   = bus.req_wen[w];
        p_addr  = bus.req_addr[w*AW +: AW];
        p_wdata = bus.req_wdata[w*DW +: DW];
        p_wmask = bus.req_wmask[w*MW +: MW];
      end
    end
  end

  // ---------------- downstream memory ----------------
  int          stall = 0;
  int          lat   = 1;
  bit          spur  = 0;
  logic [31:0] mdata = 32'h0;

  initial begin
    int  wcnt, rcnt;
    bit  hs, rv;
    wcnt = 0; rcnt = 0; hs = 0;
    bus.m_req_ready = 1'b0;
    bus.m_rsp_valid = 1'b0;
    bus.m_rsp_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      rv = 0;
      if (hs) rcnt = lat;
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) rv = 1;
      end
      bus.m_rsp_rdata = mdata;
      bus.m_rsp_valid = rv | spur;
      if (bus.m_req_valid) begin
        bus.m_req_ready = (wcnt >= stall);
        wcnt++;
      end else begin
        bus.m_req_ready = 1'b0;
        wcnt = 0;
      end
      hs = bus.m_req_valid && bus.m_req_ready;
    end
  end

  // ---------------- requesters ----------------
  task automatic set_req(input int c, input logic wn,
                         input logic [31:0] a, d,
                         input logic [3:0] m);
    bus.req_wen[c]               = wn;
    bus.req_addr[c*AW +: AW]     = a;
    bus.req_wdata[c*DW +: DW]    = d;
    bus.req_wmask[c*MW +: MW]    = m;
    bus.req_valid[c]             = 1'b1;
  endtask

  task automatic run(input int maxc);
    logic [N-1:0] d;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      d = bus.req_ready;
      if (bus.req_valid == '0 && !bus.busy) return;
      @(posedge clk);
      #1;
      bus.req_valid = bus.req_valid & ~d;
    end
    chk("run_timeout", 1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int base, r0, r1, m0;
    int e3[4];
    int e6[2];
    bus.req_valid = '0;
    bus.req_wen   = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wmask = '0;
    for (int c = 0; c < N; c++) rsp_n[c] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_m_req_valid", bus.m_req_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);

    // single read on ch0, minimum latency
    mdata = 32'h00100073;
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h80000000, 32'h0, 4'h0);
    @(negedge clk);
    chk("t1_T0_req_ready", bus.req_ready, 4'b0001);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t1_T1_m_req_valid", bus.m_req_valid, 1);
    chk("t1_T1_m_addr", bus.m_addr, 32'h80000000);
    @(negedge clk);
    chk("t1_T2_busy", bus.busy, 1);
    @(negedge clk);
    chk("t1_T3_rsp_valid", bus.rsp_valid, 4'b0001);
    chk("t1_T3_rsp_rdata", bus.rsp_rdata, 32'h00100073);
    @(negedge clk);
    chk("t1_T4_busy", bus.busy, 0);

    // write on ch1
    mdata = 32'h0badf00d;
    r0 = rsp_n[1];
    @(posedge clk); #1;
    set_req(1, 1'b1, 32'h80000104, 32'hDEADBEEF, 4'h1);
    @(negedge clk);
    chk("t2_req_ready", bus.req_ready, 4'b0010);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    chk("t2_m_wen", bus.m_wen, 1);
    chk("t2_m_wmask", bus.m_wmask, 4'h1);
    chk("t2_m_wdata", bus.m_wdata, 32'hDEADBEEF);
    run(20);
    repeat (3) @(negedge clk);
    chk("t2_one_rsp", rsp_n[1] - r0, 1);

    // ch0 and ch1 valid continuously
    base = grants.size();
    r0   = rsp_tot;
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h80001000, 32'h11, 4'hf);
    set_req(1, 1'b0, 32'h80002000, 32'h22, 4'hf);
    for (int i = 0; i < 60 && grants.size() < base + 4; i++)
      @(negedge clk);
    if (grants.size() < base + 4)
      chk("t3_grant_timeout", grants.size(), base + 4);
    @(posedge clk); #1;
    bus.req_valid = '0;
    run(40);
`ifdef MEM_ARB_FIXED_PRIO_EN
    e3 = '{0, 0, 0, 0};
`else
    e3 = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 4; i++)
      chk("t3_grant_order", gat(base + i), e3[i]);
    chk("t3_rsp_count", rsp_tot - r0, 4);

    // stalled downstream, slow response
    @(negedge clk);
    stall = 5; lat = 3; mdata = 32'h12345678;
    r0 = rsp_n[0];
    m0 = mreq_cyc;
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h80000200, 32'h55, 4'h3);
    run(40);
    repeat (2) @(negedge clk);
    chk("t4_one_rsp", rsp_n[0] - r0, 1);
    chk("t4_mreq_cycles", mreq_cyc - m0, 6);
    chk("t4_latency", r_cyc - g_cyc, 10);
    stall = 0; lat = 1;

    // spurious downstream response while idle
    r0 = rsp_tot;
    spur = 1;
    @(negedge clk);
    spur = 0;
    repeat (3) @(negedge clk);
    chk("t5_spur_busy", bus.busy, 0);
    chk("t5_spur_rsp", rsp_tot - r0, 0);

    // reset while waiting for the downstream response
    lat = 8; mdata = 32'hcafef00d;
    r0 = rsp_tot;
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h80000300, 32'h77, 4'h5);
    @(negedge clk);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_wait_busy", bus.busy, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_busy", bus.busy, 0);
    chk("t5_rst_m_req_valid", bus.m_req_valid, 0);
    chk("t5_rst_m_wen", bus.m_wen, 0);
    chk("t5_rst_m_addr", bus.m_addr, 0);
    chk("t5_rst_m_wdata", bus.m_wdata, 0);
    chk("t5_rst_m_wmask", bus.m_wmask, 0);
    chk("t5_rst_rsp_valid", bus.rsp_valid, 0);
    chk("t5_rst_rsp_rdata", bus.rsp_rdata, 0);
    repeat (12) @(negedge clk);
    chk("t5_rst_no_rsp", rsp_tot - r0, 0);
    chk("t5_rst_idle", bus.busy, 0);
    lat = 1;

    // pointer to 2, then ch3 and ch1 together
    @(posedge clk); #1;
    set_req(1, 1'b0, 32'h80000400, 32'h0, 4'h0);
    run(20);
    base = grants.size();
    r0   = rsp_n[3];
    r1   = rsp_n[1];
    @(posedge clk); #1;
    set_req(3, 1'b0, 32'h80000800, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h80000500, 32'h0, 4'h0);
    run(40);
    repeat (2) @(negedge clk);
`ifdef MEM_ARB_FIXED_PRIO_EN
    e6 = '{1, 3};
`else
    e6 = '{3, 1};
`endif
    chk("t6_first", gat(base), e6[0]);
    chk("t6_second", gat(base + 1), e6[1]);
    chk("t6_rsp_ch3", rsp_n[3] - r0, 1);
    chk("t6_rsp_ch1", rsp_n[1] - r1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arb.md
# mem_arb

Parametrised N-channel memory arbiter that serialises instruction-fetch, load/store and future requesters onto one shared memory port, replacing direct per-unit memory calls with valid/ready handshakes. Sits between the core's IFU/LSU (channel 0 = IFU, channel 1 = LSU by convention) and the single memory/bus adapter. One transaction is outstanding at a time. Every accepted request, read or write, returns exactly one response pulse to its owner.

## Interface
- NCH, 2: number of requester channels (1..8)
- AW, 32: address width
- DW, 32: data width (multiple of 8); MW = DW/8 byte-mask width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- req_valid  in  NCH  per-channel request valid
- req_ready  out  NCH  per-channel request accept (one-hot or zero)
- req_wen  in  NCH  1 = write, 0 = read
- req_addr  in  NCH*AW  channel i at bits [i*AW +: AW]
- req_wdata  in  NCH*DW  channel i at [i*DW +: DW]
- req_wmask  in  NCH*MW  channel i at [i*MW +: MW]
- rsp_valid  out  NCH  one-cycle response pulse to owner
- rsp_rdata  out  DW  read data, shared by all channels, valid with rsp_valid
- m_req_valid  out  1  downstream request valid
- m_req_ready  in  1  downstream accept
- m_wen, m_addr[AW], m_wdata[DW], m_wmask[MW]  out  latched payload
- m_rsp_valid  in  1  downstream response (read data or write ack)
- m_rsp_rdata  in  DW  downstream read data
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: if any req_valid, pick winner w and assert req_ready[w] combinationally in the same cycle. Latch w, wen, addr, wdata and wmask, then go to REQ. No req_valid: stay in IDLE, req_ready = 0.
- REQ: m_req_valid = 1; payload held stable. On m_req_ready, go to WAIT.
- WAIT: on m_rsp_valid, latch m_rsp_rdata and go to RESP.
- RESP: rsp_valid[w] = 1 for exactly one cycle and rsp_rdata = latched data. Update the round-robin pointer to (w+1) mod NCH, then go to IDLE.
- Round-robin: scan channels starting at the pointer, ascending with wrap; the first valid channel wins. Pointer resets to 0.
- Write responses: rsp_rdata is whatever m_rsp_rdata held. Requesters ignore it.
- m_rsp_valid in IDLE or REQ is ignored and does not change state.
- Requesters keep their payload stable only until req_ready; the arbiter does not re-sample after acceptance.
- No response backpressure: the owner must sink rsp_valid.
- NCH=1: degenerates to a single-channel handshake adapter, with the pointer fixed at 0.

## Timing
- Reset (rst=0 at posedge) sets: state IDLE, pointer 0, req_ready 0, rsp_valid 0, m_req_valid 0, busy 0, m_wen 0, m_addr 0, m_wdata 0, m_wmask 0, rsp_rdata 0.
- Reset mid-transaction drops the transaction with no rsp_valid. The downstream must tolerate an abandoned request.
- Minimum latency with m_req_ready=1 and m_rsp_valid one cycle after the handshake:
  - accept at T0
  - m_req_valid at T1
  - m_rsp_valid at T2
  - rsp_valid at T3
  - next accept possible at T4
- The earliest legal m_rsp_valid is the cycle after the m_req handshake.
- A new request raised during RESP is not accepted until the following IDLE cycle.

## Configuration
- MEM_ARB_FIXED_PRIO_EN. When defined: fixed priority, lowest channel index wins, and the pointer register is removed. When undefined (default): round-robin as above.

## Test plan
- Single read, ch0 addr 0x80000000. Memory: ready immediately, rsp one cycle later with 0x00100073. Expect req_ready[0] at T0, m_addr=0x80000000 at T1, rsp_valid[0] with rsp_rdata=0x00100073 at T3, busy low at T4.
- Write, ch1 addr 0x80000104, wdata 0xDEADBEEF, wmask 0x1. Expect m_wen=1, m_wmask=0x1, m_wdata=0xDEADBEEF, then a single rsp_valid[1] pulse.
- Both channels valid continuously, NCH=2, default build. Grants alternate 0,1,0,1 over 4 transactions. With MEM_ARB_FIXED_PRIO_EN, all 4 grants go to ch0.
- Downstream holds m_req_ready=0 for 5 cycles and returns m_rsp_valid 3 cycles after the handshake. m_req_valid and the payload stay stable throughout; exactly one rsp_valid is produced.
- Spurious m_rsp_valid in IDLE: no state change and no rsp_valid. rst=0 asserted while in WAIT: next cycle IDLE with all outputs at reset values; the later m_rsp_valid is ignored.
- NCH=4 with only ch3 and ch1 valid, pointer=2. ch3 wins first, then ch1.
